// File: rtl/fetch_stage_pkg.sv
// Shared types for the instruction-fetch stage.
//   addr_t        : 64-bit byte address
//   inst_t        : 32-bit instruction word
//   word_t        : 64-bit data word
//   bool          : single-bit flag
//   if_id_t       : IF/ID register contents handed to decode
//   fetch_state_t : fetch controller state, named for waveform decoding
package fetch_stage_pkg;

  typedef logic [63:0] addr_t;
  typedef logic [31:0] inst_t;
  typedef logic [63:0] word_t;
  typedef logic        bool;

  typedef struct packed {
    inst_t       inst;
    addr_t       inst_pc;
    bool         valid;
    logic [63:0] inst_counter;
  } if_id_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    HOLD  = 2'd2,
    FLUSH = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues word reads on the instruction
// bus, absorbs variable bus latency with a one-entry skid register, and honours
// downstream stall and commit-time redirect.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   ireq_valid / ireq_addr     fetch request, held until iresp_data_ok
//   iresp_data_ok / iresp_data one-cycle response pulse and instruction word
//   stall                      decode cannot accept; out holds
//   redirect_valid/redirect_pc redirect from commit (overrides stall)
//   out                        IF/ID register to decode
//
// state | meaning
// IDLE  | after reset; first request issued next cycle
// REQ   | request outstanding at ireq_addr
// HOLD  | word parked in skid, decode stalled, no request on the bus
// FLUSH | redirected while a request was outstanding; its response is dropped
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter addr_t RESET_PC = 64'h8000_0000
) (
  input  logic   clk,
  input  logic   reset,
  output logic   ireq_valid,
  output addr_t  ireq_addr,
  input  logic   iresp_data_ok,
  input  inst_t  iresp_data,
  input  logic   stall,
  input  logic   redirect_valid,
  input  addr_t  redirect_pc,
  output if_id_t out
);

  fetch_state_t state_q;
  addr_t        pc_q;
  addr_t        req_addr_q;   // address of the request on the bus; kept through FLUSH
  if_id_t       out_q;
  inst_t        skid_inst_q;
  addr_t        skid_pc_q;
  logic [63:0]  counter_q;

  addr_t redirect_tgt;
  logic  slot_free;

  assign redirect_tgt = redirect_pc & ~64'h3;
  assign slot_free    = !out_q.valid || !stall;

  assign ireq_valid = (state_q == REQ) || (state_q == FLUSH);
  assign ireq_addr  = req_addr_q;
  assign out        = out_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      out_q       <= '0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
      counter_q   <= '0;
    end else if (redirect_valid) begin
      out_q.valid <= 1'b0;
      skid_inst_q <= '0;
      skid_pc_q   <= '0;
      pc_q        <= redirect_tgt;
      // An outstanding request must stay on the bus at its old address until
      // its response arrives; only then can the new target be requested.
      if (ireq_valid && !iresp_data_ok) begin
        state_q <= FLUSH;
      end else begin
        state_q    <= REQ;
        req_addr_q <= redirect_tgt;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_q    <= REQ;
          req_addr_q <= pc_q;
        end
        REQ: begin
          if (iresp_data_ok) begin
            if (slot_free) begin
              out_q      <= '{inst: iresp_data, inst_pc: pc_q, valid: 1'b1,
                              inst_counter: counter_q};
              counter_q  <= counter_q + 64'd1;
              pc_q       <= pc_q + 64'd4;
              req_addr_q <= pc_q + 64'd4;
            end else begin
              skid_inst_q <= iresp_data;
              skid_pc_q   <= pc_q;
              state_q     <= HOLD;
            end
          end else if (!stall) begin
            out_q.valid <= 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            out_q      <= '{inst: skid_inst_q, inst_pc: skid_pc_q, valid: 1'b1,
                            inst_counter: counter_q};
            counter_q  <= counter_q + 64'd1;
            pc_q       <= pc_q + 64'd4;
            req_addr_q <= pc_q + 64'd4;
            state_q    <= REQ;
          end
        end
        FLUSH: begin
          if (iresp_data_ok) begin
            state_q    <= REQ;
            req_addr_q <= pc_q;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  localparam int CW = $bits(if_id_t);

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  logic   ireq_valid;
  addr_t  ireq_addr;
  logic   iresp_data_ok = 1'b0;
  inst_t  iresp_data = '0;
  logic   stall = 1'b0;
  logic   redirect_valid = 1'b0;
  addr_t  redirect_pc = '0;
  if_id_t out;

  int total = 0;
  int bad = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_PC(64'h8000_0000)) dut (
    .clk(clk), .reset(reset),
    .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
    .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
    .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out(out)
  );

  task automatic chk(input string nm, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, got, exp, $time);
    end
  endtask

  function automatic if_id_t mk(input inst_t i, input addr_t a, input bit v, input logic [63:0] c);
    return '{inst: i, inst_pc: a, valid: v, inst_counter: c};
  endfunction

  // ---------------- behavioural model ----------------
  // Tracks "is a fetch outstanding", "will its response be discarded", the
  // address being fetched, a queue of words waiting for decode, and what
  // decode currently sees.
  typedef struct packed { inst_t i; addr_t a; } ent_t;
  bit          m_started, m_busy, m_drop;
  addr_t       m_pc, m_raddr;
  logic [63:0] m_cnt;
  if_id_t      m_out;
  ent_t        m_wait[$];

  always @(posedge clk) begin
    bit resp;
    addr_t tgt;
    ent_t e;
    resp = m_busy && iresp_data_ok;
    tgt  = {redirect_pc[63:2], 2'b00};
    if (reset) begin
      m_started = 0; m_busy = 0; m_drop = 0;
      m_pc = 64'h8000_0000; m_raddr = 64'h8000_0000;
      m_cnt = 0; m_out = '0; m_wait.delete();
    end else if (redirect_valid) begin
      m_started = 1;
      m_out.valid = 1'b0;
      m_wait.delete();
      m_pc = tgt;
      if (m_busy && !iresp_data_ok) m_drop = 1;
      else begin m_busy = 1; m_raddr = tgt; m_drop = 0; end
    end else if (!m_started) begin
      m_started = 1; m_busy = 1; m_raddr = m_pc;
    end else if (resp && m_drop) begin
      m_drop = 0; m_raddr = m_pc;
    end else if (resp) begin
      if (!m_out.valid || !stall) begin
        m_out = mk(iresp_data, m_raddr, 1'b1, m_cnt);
        m_cnt++;
        m_pc = m_raddr + 4;
        m_raddr = m_pc;
      end else begin
        m_wait.push_back('{i: iresp_data, a: m_raddr});
        m_busy = 0;
      end
    end else if (m_wait.size() != 0 && !stall) begin
      e = m_wait.pop_front();
      m_out = mk(e.i, e.a, 1'b1, m_cnt);
      m_cnt++;
      m_pc = e.a + 4;
      m_raddr = m_pc;
      m_busy = 1;
    end else if (m_out.valid && !stall) begin
      m_out.valid = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      chk("mdl_ireq_valid", CW'(ireq_valid), CW'(m_busy));
      if (m_busy) chk("mdl_ireq_addr", CW'(ireq_addr), CW'(m_raddr));
      chk("mdl_out", CW'(out), CW'(m_out));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    iresp_data_ok = 0; redirect_valid = 0; stall = 0;
  endtask

  initial begin
    int lat;
    reset = 1;
    step();
    mon_en = 1;
    step();
    chk("rst_ireq_valid", CW'(ireq_valid), CW'(1'b0));
    chk("rst_out", CW'(out), CW'(0));
    reset = 0;
    step();                                   // IDLE -> REQ
    chk("t1_req_valid", CW'(ireq_valid), CW'(1'b1));
    chk("t1_req_addr", CW'(ireq_addr), CW'(64'h8000_0000));
    iresp_data_ok = 1; iresp_data = 32'h0000_0013;
    step(); idle_in();
    chk("t1_out", CW'(out), CW'(mk(32'h13, 64'h8000_0000, 1, 0)));
    chk("t1_next_addr", CW'(ireq_addr), CW'(64'h8000_0004));

    // 2: stall with valid output -> skid/HOLD
    stall = 1; iresp_data_ok = 1; iresp_data = 32'h0000_0093;
    step(); iresp_data_ok = 0;
    chk("t2_hold_valid", CW'(ireq_valid), CW'(1'b0));
    chk("t2_out_held", CW'(out), CW'(mk(32'h13, 64'h8000_0000, 1, 0)));
    step();
    chk("t2_out_held2", CW'(out), CW'(mk(32'h13, 64'h8000_0000, 1, 0)));
    stall = 0;
    step();
    chk("t2_skid_out", CW'(out), CW'(mk(32'h93, 64'h8000_0004, 1, 1)));
    chk("t2_next_addr", CW'(ireq_addr), CW'(64'h8000_0008));

    // 3: redirect while request pending -> FLUSH
    redirect_valid = 1; redirect_pc = 64'h8000_0100;
    step(); idle_in();
    chk("t3_flush_addr", CW'(ireq_addr), CW'(64'h8000_0008));
    chk("t3_out_invalid", CW'(out.valid), CW'(1'b0));
    step();
    chk("t3_flush_addr2", CW'(ireq_addr), CW'(64'h8000_0008));
    iresp_data_ok = 1; iresp_data = 32'hDEAD_BEEF;
    step(); idle_in();
    chk("t3_new_addr", CW'(ireq_addr), CW'(64'h8000_0100));
    chk("t3_dropped", CW'(out.valid), CW'(1'b0));

    // 4: redirect same cycle as data_ok
    iresp_data_ok = 1; iresp_data = 32'h0000_00AA;
    redirect_valid = 1; redirect_pc = 64'h8000_0200;
    step(); idle_in();
    chk("t4_out_invalid", CW'(out.valid), CW'(1'b0));
    chk("t4_new_addr", CW'(ireq_addr), CW'(64'h8000_0200));
    iresp_data_ok = 1; iresp_data = 32'h0000_0217;
    step(); idle_in();
    chk("t4_out", CW'(out), CW'(mk(32'h217, 64'h8000_0200, 1, 2)));

    // 5: unaligned target and back-to-back redirects in FLUSH
    iresp_data_ok = 1; iresp_data = 32'h0000_0BAD;
    redirect_valid = 1; redirect_pc = 64'h8000_0102;
    step(); idle_in();
    chk("t5_aligned", CW'(ireq_addr), CW'(64'h8000_0100));
    redirect_valid = 1; redirect_pc = 64'h8000_0300;
    step();
    redirect_pc = 64'h8000_0404;
    step();
    redirect_pc = 64'h8000_0507;
    step(); idle_in();
    chk("t5_flush_addr", CW'(ireq_addr), CW'(64'h8000_0100));
    iresp_data_ok = 1;
    step(); idle_in();
    chk("t5_last_target", CW'(ireq_addr), CW'(64'h8000_0504));
    iresp_data_ok = 1; iresp_data = 32'h0000_0333;
    step(); idle_in();
    chk("t5_out", CW'(out), CW'(mk(32'h333, 64'h8000_0504, 1, 3)));

    // 6: reset in FLUSH with a stale response
    redirect_valid = 1; redirect_pc = 64'h8000_0600;
    step(); idle_in();
    reset = 1; iresp_data_ok = 1;
    step();
    chk("t6_rst_out", CW'(out), CW'(0));
    chk("t6_rst_valid", CW'(ireq_valid), CW'(1'b0));
    reset = 0;                                 // stale data_ok seen while IDLE
    step(); idle_in();
    chk("t6_first_addr", CW'(ireq_addr), CW'(64'h8000_0000));
    chk("t6_stale_ignored", CW'(out), CW'(0));
    iresp_data_ok = 1; iresp_data = 32'h0000_0513;
    step(); idle_in();
    chk("t6_out", CW'(out), CW'(mk(32'h513, 64'h8000_0000, 1, 0)));

    // 7: PC wrap at top of address space
    redirect_valid = 1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFFF;
    step(); idle_in();
    iresp_data_ok = 1;
    step(); idle_in();
    chk("t7_top_addr", CW'(ireq_addr), CW'(64'hFFFF_FFFF_FFFF_FFFC));
    iresp_data_ok = 1; iresp_data = 32'h0000_0006;
    step(); idle_in();
    chk("t7_out", CW'(out), CW'(mk(32'h6, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1)));
    chk("t7_wrap_addr", CW'(ireq_addr), CW'(64'h0));

    // 8: mixed traffic, checked cycle-by-cycle by the model
    lat = 1;
    for (int n = 0; n < 400; n++) begin
      iresp_data_ok = 0;
      if (ireq_valid) begin
        if (lat == 0) begin
          iresp_data_ok = 1;
          iresp_data = ireq_addr[31:0] ^ 32'h5A5A_0000;
          lat = $urandom_range(0, 2);
        end else lat--;
      end
      stall = ($urandom_range(0, 2) == 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc = {32'h0, $urandom};
      step();
    end
    idle_in();
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
